// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes
// and the alu_op codes that alu_control also decodes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    ALU_WB    = 4'd8,
    EXEC_I    = 4'd9,
    I_WB      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_encoder.sv
// Maps an I-type opcode to its ALU operation class and immediate extension;
// non-I-type opcodes fall back to add with sign extension.
module alu_op_encoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] alu_op,
  output logic       zero_ext
);

  always_comb begin
    alu_op   = ALU_ADD;
    zero_ext = 1'b0;
    case (opcode)
      OP_ANDI: begin alu_op = ALU_AND; zero_ext = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  zero_ext = 1'b1; end
      OP_XORI: begin alu_op = ALU_XOR; zero_ext = 1'b1; end
      OP_SLTI: alu_op = ALU_SLT;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// through its states and drives the datapath enables and the alu_op class.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               zero_ext,
  output logic [2:0]         alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t     cur_state, nxt_state;
  logic [2:0] enc_alu_op, alu_class_q;
  logic       enc_zero_ext, zero_ext_q, is_store_q;

  alu_op_encoder u_alu_op_encoder (
    .opcode   (opcode),
    .alu_op   (enc_alu_op),
    .zero_ext (enc_zero_ext)
  );

  // Decode-time facts are captured so the opcode may change once DECODE is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= IDLE;
      alu_class_q <= ALU_ADD;
      zero_ext_q  <= 1'b0;
      is_store_q  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == DECODE) begin
        alu_class_q <= enc_alu_op;
        zero_ext_q  <= enc_zero_ext;
        is_store_q  <= (opcode == OP_SW);
      end
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    zero_ext      = 1'b0;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (cur_state)
      IDLE: nxt_state = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nxt_state = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_RTYPE)                        nxt_state = EXEC_R;
        else if (opcode == OP_LW || opcode == OP_SW)   nxt_state = MEM_ADDR;
        else if (opcode == OP_BEQ)                     nxt_state = BRANCH;
        else if (opcode == OP_J)                       nxt_state = JUMP;
        else if (is_itype(opcode))                     nxt_state = EXEC_I;
        else begin
          illegal_op = 1'b1;
          nxt_state  = FETCH;
        end
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = is_store_q ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) nxt_state = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt_state  = FETCH;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) nxt_state = FETCH;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
        nxt_state = ALU_WB;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        nxt_state  = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = alu_class_q;
        zero_ext  = zero_ext_q;
        nxt_state = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt_state  = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        nxt_state     = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        nxt_state  = FETCH;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle's expected control vector
// is queued when inputs are driven and compared against the DUT after settling.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic       zero_ext;
    logic [2:0] alu_op;
    logic       instr_done, illegal_op;
  } obs_t;

  logic       clk, rst_n, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext;
  logic       instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  obs_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [2:0] exp_ialu = 3'b000;
  logic       exp_ize  = 1'b0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .zero_ext(zero_ext), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control vector for a state, written from the datapath control table.
  function automatic obs_t model(input state_t s, input logic rdy, input logic [5:0] op);
    obs_t o;
    logic legal;
    o = '0;
    o.st = s;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000) ||
            (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110) ||
            (op == 6'b001010);
    case (s)
      FETCH:     begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      DECODE:    begin o.alu_src_b = 2'b11; o.illegal_op = !legal; end
      MEM_ADDR:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      MEM_READ:  begin o.mem_read = 1; o.i_or_d = 1; end
      MEM_WB:    begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      MEM_WRITE: begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = rdy; end
      EXEC_R:    begin o.alu_src_a = 1; o.alu_op = 3'b010; end
      ALU_WB:    begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
      EXEC_I:    begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = exp_ialu; o.zero_ext = exp_ize; end
      I_WB:      begin o.reg_write = 1; o.instr_done = 1; end
      BRANCH:    begin o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_write_cond = 1; o.pc_source = 2'b01; o.instr_done = 1; end
      JUMP:      begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
      default:   ;
    endcase
    return o;
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic rdy, input state_t s);
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(model(s, rdy, op));
  endtask

  task automatic checkOutput(input string tag);
    obs_t got, exp;
    #1;
    got = '{st: state, pc_write: pc_write, pc_write_cond: pc_write_cond, i_or_d: i_or_d,
            mem_read: mem_read, mem_write: mem_write, ir_write: ir_write,
            mem_to_reg: mem_to_reg, reg_dst: reg_dst, reg_write: reg_write,
            alu_src_a: alu_src_a, alu_src_b: alu_src_b, pc_source: pc_source,
            zero_ext: zero_ext, alu_op: alu_op, instr_done: instr_done,
            illegal_op: illegal_op};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=<empty scoreboard>", tag, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
    end
  endtask

  task automatic step(input logic [5:0] op, input logic rdy, input state_t s, input string tag);
    applyStimulus(op, rdy, s);
    checkOutput(tag);
    @(negedge clk);
  endtask

  logic [5:0] iop_tab[5];
  logic [2:0] ialu_tab[5];
  logic       ize_tab[5];

  initial begin
    iop_tab  = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
    ialu_tab = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b110};
    ize_tab  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0;
    @(negedge clk);
    step(6'b000000, 1'b1, IDLE, "reset_idle");
    rst_n = 1'b1;
    step(6'b000000, 1'b1, IDLE, "idle_release");

    // R-type, memory always ready.
    step(6'b000000, 1'b1, FETCH,  "r_fetch");
    step(6'b000000, 1'b1, DECODE, "r_decode");
    step(6'b000000, 1'b1, EXEC_R, "r_exec");
    step(6'b000000, 1'b1, ALU_WB, "r_wb");

    // lw with two wait cycles in MEM_READ; opcode scrambled after DECODE.
    step(6'b100011, 1'b1, FETCH,    "lw_fetch");
    step(6'b100011, 1'b1, DECODE,   "lw_decode");
    step(6'b101011, 1'b1, MEM_ADDR, "lw_addr");
    step(6'b101011, 1'b0, MEM_READ, "lw_wait0");
    step(6'b101011, 1'b0, MEM_READ, "lw_wait1");
    step(6'b101011, 1'b1, MEM_READ, "lw_read");
    step(6'b101011, 1'b1, MEM_WB,   "lw_wb");

    // sw with one FETCH wait.
    step(6'b101011, 1'b0, FETCH,     "sw_fetch_wait");
    step(6'b101011, 1'b1, FETCH,     "sw_fetch");
    step(6'b101011, 1'b1, DECODE,    "sw_decode");
    step(6'b100011, 1'b1, MEM_ADDR,  "sw_addr");
    step(6'b100011, 1'b1, MEM_WRITE, "sw_write");

    // I-types; opcode forced to R-type in EXEC_I must not disturb alu_op.
    for (int i = 0; i < 5; i++) begin
      exp_ialu = ialu_tab[i];
      exp_ize  = ize_tab[i];
      step(iop_tab[i],  1'b1, FETCH,  $sformatf("i%0d_fetch", i));
      step(iop_tab[i],  1'b1, DECODE, $sformatf("i%0d_decode", i));
      step(6'b000000,   1'b1, EXEC_I, $sformatf("i%0d_exec", i));
      step(6'b000000,   1'b1, I_WB,   $sformatf("i%0d_wb", i));
    end

    step(6'b000100, 1'b1, FETCH,  "beq_fetch");
    step(6'b000100, 1'b1, DECODE, "beq_decode");
    step(6'b000100, 1'b1, BRANCH, "beq_branch");
    step(6'b000010, 1'b1, FETCH,  "j_fetch");
    step(6'b000010, 1'b1, DECODE, "j_decode");
    step(6'b000010, 1'b1, JUMP,   "j_jump");

    step(6'b111111, 1'b1, FETCH,  "ill_fetch");
    step(6'b111111, 1'b1, DECODE, "ill_decode");

    // sw stalled in MEM_WRITE, then asynchronous reset.
    step(6'b101011, 1'b1, FETCH,    "sw2_fetch");
    step(6'b101011, 1'b1, DECODE,   "sw2_decode");
    step(6'b101011, 1'b1, MEM_ADDR, "sw2_addr");
    applyStimulus(6'b101011, 1'b0, MEM_WRITE);
    checkOutput("sw2_stall");
    rst_n = 1'b0;
    applyStimulus(6'b101011, 1'b0, IDLE);
    checkOutput("rst_async");
    @(negedge clk);
    step(6'b101011, 1'b1, IDLE, "rst_hold");
    rst_n = 1'b1;
    step(6'b000000, 1'b1, IDLE,  "rst_idle");
    step(6'b000000, 1'b1, FETCH, "rst_fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
